// File: rtl/fetch_unit.sv
// fetch_unit: PC register and fetch buffer feeding decode, with redirect and stall support.
// Ports: clk/rst (sync, active-high); imem_addr/imem_inst combinational ROM access;
// redirect_valid/redirect_pc restart fetch at a new target; out_valid/out_ready/out_inst/out_pc
// form the decode handshake. Define FETCH_BUF_EN for a 2-entry fetch FIFO (default: 1 entry).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);
`ifdef FETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    logic [31:0]             pc_q, pc_d;
    logic [DEPTH-1:0][31:0]  ent_pc_q, ent_pc_d, ent_inst_q, ent_inst_d;
    logic [1:0]              cnt_q, cnt_d, wr_idx;
    logic                    pop, push;
    logic                    unused_lsbs;
    assign unused_lsbs = ^redirect_pc[1:0];
    assign imem_addr = pc_q;
    assign out_valid = cnt_q != 2'd0;
    assign out_pc    = out_valid ? ent_pc_q[0] : '0;
    assign out_inst  = out_valid ? ent_inst_q[0] : '0;
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign push      = ~redirect_valid & ((cnt_q < 2'(DEPTH)) | pop);
    assign wr_idx    = cnt_q - 2'(pop);
    always_comb begin
        ent_pc_d   = ent_pc_q;
        ent_inst_d = ent_inst_q;
`ifdef FETCH_BUF_EN
        if (pop) begin
            ent_pc_d[0]   = ent_pc_q[1];
            ent_inst_d[0] = ent_inst_q[1];
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_idx == 2'(i)) begin
                ent_pc_d[i]   = pc_q;
                ent_inst_d[i] = imem_inst;
            end
        end
        cnt_d = redirect_valid ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
        pc_d  = redirect_valid ? {redirect_pc[31:2], 2'b00} : (push ? pc_q + 32'd4 : pc_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= {RESET_PC[31:2], 2'b00};
            cnt_q      <= 2'd0;
            ent_pc_q   <= '0;
            ent_inst_q <= '0;
        end else begin
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            ent_pc_q   <= ent_pc_d;
            ent_inst_q <= ent_inst_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue-based model.
module tb_fetch_unit;
    localparam logic [31:0] RP = 32'h0000_0100;
`ifdef FETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_inst, out_inst, out_pc;
    logic        out_valid;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_pc = RP;
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_inst = rom(imem_addr);

    fetch_unit #(.RESET_PC(RP)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
    );

    // Drive one cycle of inputs and advance the reference model: a FIFO of fetched
    // addresses of capacity DEPTH plus the next address to fetch.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic pop, acc;
        rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        @(posedge clk);
        if (r) begin
            mq.delete(); m_pc = RP;
        end else if (rv) begin
            mq.delete(); m_pc = {rpc[31:2], 2'b00};
        end else begin
            pop = (mq.size() > 0) && rdy;
            acc = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (acc) begin mq.push_back(m_pc); m_pc = m_pc + 32'd4; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 32'h0000_0800, 1);
        total++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
            bad++; $display("FAIL reset_out: valid=%b pc=%h inst=%h want 0/0/0", out_valid, out_pc, out_inst);
        end
        total++;
        if (imem_addr !== RP) begin
            bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, RP);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            total++;
            if (out_valid !== 1'b1 || out_pc !== RP + 32'(4 * i) || out_inst !== rom(RP + 32'(4 * i))) begin
                bad++; $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h want pc %h", i, out_valid, out_pc, out_inst, RP + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] head;
        head = out_pc;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            total++;
            if (out_valid !== 1'b1 || out_pc !== head || out_inst !== rom(head)) begin
                bad++; $display("FAIL stall_hold[%0d]: pc=%h inst=%h want %h", i, out_pc, out_inst, head);
            end
        end
        total++;
        if (imem_addr !== head + 32'(4 * DEPTH)) begin
            bad++; $display("FAIL stall_pc: got %h want %h", imem_addr, head + 32'(4 * DEPTH));
        end
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 0, 1);
            total++;
            if (out_valid !== 1'b1 || out_pc !== head + 32'(4 * k)) begin
                bad++; $display("FAIL stall_release[%0d]: pc=%h want %h", k, out_pc, head + 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        step(0, 1, 32'h0000_0043, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL redir_gap: valid=%b want 0", out_valid);
        end
        step(0, 0, 0, 1);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== rom(32'h40)) begin
            bad++; $display("FAIL redir_target: pc=%h valid=%b want 00000040", out_pc, out_valid);
        end
        step(0, 0, 0, 1);
        total++;
        if (out_pc !== 32'h44) begin
            bad++; $display("FAIL redir_next: pc=%h want 00000044", out_pc);
        end
    endtask

    task automatic test_redirect_full();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0200, 0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL full_flush: valid=%b want 0", out_valid);
        end
        step(0, 0, 0, 0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
            bad++; $display("FAIL full_target: pc=%h want 00000200", out_pc);
        end
        step(0, 0, 0, 1);
        total++;
        if (out_pc !== 32'h204) begin
            bad++; $display("FAIL full_next: pc=%h want 00000204", out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        step(0, 1, 32'hFFFF_FFF8, 1);
        exp = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            total++;
            if (out_valid !== 1'b1 || out_pc !== exp || out_inst !== rom(exp)) begin
                bad++; $display("FAIL wrap[%0d]: pc=%h want %h", i, out_pc, exp);
            end
            exp = exp + 32'd4;
        end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 32'h0000_0300, 1);
        step(0, 1, 32'h0000_0400, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_gap: valid=%b want 0", out_valid);
        end
        step(0, 0, 0, 1);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
            bad++; $display("FAIL b2b_target: pc=%h want 00000400", out_pc);
        end
        step(0, 0, 0, 1);
        total++;
        if (out_pc !== 32'h404) begin
            bad++; $display("FAIL b2b_next: pc=%h want 00000404", out_pc);
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0500, 0);
        step(1, 1, 32'h0000_0600, 0);
        total++;
        if (out_valid !== 1'b0 || imem_addr !== RP) begin
            bad++; $display("FAIL rst_mid: valid=%b addr=%h want 0/%h", out_valid, imem_addr, RP);
        end
        step(0, 0, 0, 1);
        total++;
        if (out_valid !== 1'b1 || out_pc !== RP) begin
            bad++; $display("FAIL rst_restart: pc=%h want %h", out_pc, RP);
        end
    endtask

    task automatic test_random();
        logic        r, rv, rdy;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom % 40) == 0;
            rv  = ($urandom % 8) == 0;
            rpc = $urandom;
            rdy = ($urandom % 3) != 0;
            step(r, rv, rpc, rdy);
            total++;
            if (out_valid !== (mq.size() > 0) || imem_addr !== m_pc ||
                (mq.size() > 0 && (out_pc !== mq[0] || out_inst !== rom(mq[0])))) begin
                bad++;
                $display("FAIL random[%0d]: valid=%b pc=%h addr=%h want valid=%b pc=%h addr=%h",
                         i, out_valid, out_pc, imem_addr, mq.size() > 0,
                         (mq.size() > 0) ? mq[0] : 32'h0, m_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_full();
        test_wrap();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
